lfsr_checker: RTL and testbench
===============================

LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 SHALL have parameter LOCK_THRESH, default 8, giving the consecutive matches in ACQ needed to lock (range 1..15).
REQ-002 SHALL have parameter LOSS_THRESH, default 3, giving the consecutive mismatches in LOCKED needed to drop lock (range 1..7).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: in_bit is sampled this cycle.
REQ-006 SHALL have port in_bit, input, 1 bit: received serial PRBS bit.
REQ-007 SHALL have port err_clr, input, 1 bit: synchronous clear of err_count.
REQ-008 SHALL have port locked, output, 1 bit: checker is synchronised to the sequence.
REQ-009 SHALL have port err_pulse, output, 1 bit: one-cycle flag for each mismatch while LOCKED.
REQ-010 SHALL have port err_count, output, 8 bits: saturating count of errors seen while LOCKED.
REQ-011 SHALL have port bit_count, output, 16 bits: count of bits checked while LOCKED (see Configuration).

Function
REQ-012 SHALL check the 4-bit maximal sequence b[n] = b[n-1] XOR b[n-4] (x^4+x^3+1, period 15).
REQ-013 SHALL hold a 4-bit history hist (hist[0] = newest) and compute pred = hist[0] XOR hist[3].
REQ-014 SHALL change state, history and counters only on cycles with in_valid=1; err_clr is the only exception.
REQ-015 SHALL implement states HUNT, ACQ and LOCKED.
REQ-016 HUNT SHALL shift in_bit into hist and increment a fill counter that saturates at 4.
REQ-017 HUNT SHALL move to ACQ once the fill counter is 4 and the updated hist is non-zero; otherwise it stays in HUNT.
REQ-018 ACQ SHALL shift in_bit into hist on every valid bit.
REQ-019 In ACQ, a match SHALL increment match_cnt and a mismatch SHALL clear it to 0.
REQ-020 ACQ SHALL move to LOCKED when match_cnt reaches LOCK_THRESH.
REQ-021 ACQ SHALL return to HUNT, with the fill counter cleared, if the updated hist is 0000.
REQ-022 LOCKED SHALL shift pred (flywheel) into hist, not in_bit.
REQ-023 In LOCKED, a match SHALL clear miss_cnt.
REQ-024 In LOCKED, a mismatch SHALL set err_pulse for the next cycle, increment err_count (saturating at 255) and increment miss_cnt.
REQ-025 LOCKED SHALL go to HUNT, clearing the fill counter, match_cnt and miss_cnt, when miss_cnt reaches LOSS_THRESH.
REQ-026 All outputs SHALL be registered.
REQ-027 locked SHALL be high exactly while the state is LOCKED, rising in the cycle after the validating bit is accepted.
REQ-028 err_pulse SHALL be low on any cycle without a LOCKED mismatch, including in_valid=0 cycles.
REQ-029 err_clr SHALL set err_count to 0 and take priority over a simultaneous increment.
REQ-030 err_clr SHALL NOT affect err_pulse or the state.
REQ-031 err_count SHALL NOT clear on loss of lock.

Reset
REQ-032 While rst_n=0, the block SHALL be asynchronously in HUNT, with hist=0000, all internal counters 0, locked=0, err_pulse=0, err_count=0 and bit_count=0.
REQ-033 Reset asserted mid-operation SHALL abandon lock immediately, with no partial update on deassertion.

Configuration
REQ-034 With macro LFSR_CHK_BITCNT_EN defined, bit_count SHALL increment (saturating at 65535) on every valid bit accepted in LOCKED, and SHALL clear with err_clr.
REQ-035 Without LFSR_CHK_BITCNT_EN, bit_count SHALL remain as a port driven constant 0 and no counter logic SHALL be built.

Verification
REQ-036 Reset, then continuous valid stream 111101011001000 repeating (first bit first), defaults -> locked=1 in the cycle after the 12th valid bit; err_count=0.
REQ-037 Once locked, invert one bit -> err_pulse high for exactly 1 cycle, err_count=1, locked remains 1, and the next 15 bits produce no error.
REQ-038 Once locked, invert 3 consecutive bits -> err_count=3 and locked=0 after the 3rd; the correct stream then relocks 12 valid bits later.
REQ-039 Constant in_bit=0 for 100 valid cycles -> locked stays 0, state stays HUNT, err_count=0; with in_valid toggling 1/0 on the REQ-036 stream -> lock after the 12th valid bit (23 cycles).
REQ-040 err_clr asserted on the same cycle as a LOCKED mismatch with err_count=5 -> err_count=0 and err_pulse=1.
REQ-041 rst_n pulsed low mid-lock -> locked, err_count and bit_count go to 0 without waiting for a clock edge.
REQ-042 With LFSR_CHK_BITCNT_EN defined, 30 clean bits after lock -> bit_count=30; without it, bit_count stays 0.

Source files
------------

// File: rtl/lfsr_checker.sv
// PRBS checker for the x^4+x^3+1 sequence: hunts, acquires, then flywheels while locked.
// Optional bit counter enabled by defining LFSR_CHK_BITCNT_EN.
module lfsr_checker #(
  parameter int LOCK_THRESH = 8,
  parameter int LOSS_THRESH = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        in_bit,
  input  logic        err_clr,
  output logic        locked,
  output logic        err_pulse,
  output logic [7:0]  err_count,
  output logic [15:0] bit_count,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  hist_q, hist_d;
  logic [2:0]  fill_q, fill_d;
  logic [3:0]  match_q, match_d;
  logic [2:0]  miss_q, miss_d;
  logic        locked_q, locked_d;
  logic        err_pulse_q, err_pulse_d;
  logic [7:0]  err_count_q, err_count_d;
  logic        pred;
  logic        mismatch;

  assign pred     = hist_q[0] ^ hist_q[3];
  assign mismatch = in_bit != pred;

  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    fill_d      = fill_q;
    match_d     = match_q;
    miss_d      = miss_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;
    if (in_valid) begin
      case (state_q)
        HUNT: begin
          hist_d  = {hist_q[2:0], in_bit};
          match_d = 4'd0;
          if (fill_q != 3'd4) fill_d = fill_q + 3'd1;
          if (fill_d == 3'd4 && hist_d != 4'd0) state_d = ACQ;
        end
        ACQ: begin
          hist_d  = {hist_q[2:0], in_bit};
          match_d = mismatch ? 4'd0 : match_q + 4'd1;
          // An all-zero history is the lockup state; it can never predict the sequence.
          if (hist_d == 4'd0) begin
            state_d = HUNT;
            fill_d  = 3'd0;
            match_d = 4'd0;
          end else if (match_d == 4'(LOCK_THRESH)) begin
            state_d = LOCKED;
            match_d = 4'd0;
            miss_d  = 3'd0;
          end
        end
        LOCKED: begin
          // Flywheel: the history follows our own prediction, so bit errors do not corrupt it.
          hist_d = {hist_q[2:0], pred};
          if (mismatch) begin
            err_pulse_d = 1'b1;
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
            miss_d = miss_q + 3'd1;
            if (miss_d == 3'(LOSS_THRESH)) begin
              state_d = HUNT;
              fill_d  = 3'd0;
              match_d = 4'd0;
              miss_d  = 3'd0;
            end
          end else begin
            miss_d = 3'd0;
          end
        end
        default: state_d = HUNT;
      endcase
    end
    if (err_clr) err_count_d = 8'd0;
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      hist_q      <= 4'd0;
      fill_q      <= 3'd0;
      match_q     <= 4'd0;
      miss_q      <= 3'd0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

`ifdef LFSR_CHK_BITCNT_EN
  logic [15:0] bit_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q <= 16'd0;
    end else if (err_clr) begin
      bit_cnt_q <= 16'd0;
    end else if (in_valid && state_q == LOCKED && bit_cnt_q != 16'hFFFF) begin
      bit_cnt_q <= bit_cnt_q + 16'd1;
    end
  end

  assign bit_count = bit_cnt_q;
`else
  assign bit_count = 16'd0;
`endif

  assign locked      = locked_q;
  assign err_pulse   = err_pulse_q;
  assign err_count   = err_count_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: lock, single/burst errors, err_clr, reset, idle-gap streams.
module tb_lfsr_checker;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_bit;
  logic        err_clr;
  logic        locked;
  logic        err_pulse;
  logic [7:0]  err_count;
  logic [15:0] bit_count;
  logic [1:0]  dbg_state;

  int tests;
  int fails;
  int idx;
  logic [7:0] exp_q[$];

  localparam logic [1:0] ST_HUNT = 2'd0;

  lfsr_checker dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .err_clr     (err_clr),
    .locked      (locked),
    .err_pulse   (err_pulse),
    .err_count   (err_count),
    .bit_count   (bit_count),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic prbs(input int i);
    logic [14:0] p;
    p = 15'b111101011001000;
    return p[14 - (i % 15)];
  endfunction

  function automatic logic [15:0] exp_bits(input int n);
`ifdef LFSR_CHK_BITCNT_EN
    return 16'(n);
`else
    return 16'd0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // drivers: each call consumes exactly one rising edge, then samples 1 time unit later
  task automatic send(input logic v, input logic b, input logic c);
    in_valid = v;
    in_bit   = b;
    err_clr  = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    err_clr  = 1'b0;
  endtask

  task automatic send_prbs(input logic inv, input logic c);
    send(1'b1, prbs(idx) ^ inv, c);
    idx++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    idx = 0;
  endtask

  // scoreboard for err_pulse sequence
  task automatic score_pulse(input string tag);
    logic [7:0] e;
    e = exp_q.pop_front();
    check(tag, {31'd0, err_pulse}, {24'd0, e});
  endtask

  initial begin
    tests = 0; fails = 0; idx = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; err_clr = 1'b0;
    #2;
    check("rst_locked", locked, 0);
    check("rst_err_pulse", err_pulse, 0);
    check("rst_err_count", err_count, 0);
    check("rst_bit_count", bit_count, 0);
    check("rst_state", dbg_state, ST_HUNT);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;

    // clean stream locks after 12th valid bit
    for (int i = 0; i < 11; i++) send_prbs(1'b0, 1'b0);
    check("lock_before_12", locked, 0);
    send_prbs(1'b0, 1'b0);
    check("lock_at_12", locked, 1);
    check("lock_err_count", err_count, 0);

    // single inverted bit then 15 clean bits
    exp_q.push_back(8'd1);
    for (int i = 0; i < 15; i++) exp_q.push_back(8'd0);
    send_prbs(1'b1, 1'b0);
    score_pulse("single_err_pulse");
    check("single_err_count", err_count, 1);
    check("single_locked", locked, 1);
    for (int i = 0; i < 15; i++) begin
      send_prbs(1'b0, 1'b0);
      score_pulse("clean_after_err");
    end
    check("clean_err_count", err_count, 1);
    check("bit_count_16", bit_count, exp_bits(16));

    // err_clr on an idle cycle
    send(1'b0, 1'b1, 1'b1);
    check("clr_err_count", err_count, 0);
    check("clr_bit_count", bit_count, 0);
    check("clr_locked", locked, 1);
    check("idle_err_pulse", err_pulse, 0);

    for (int i = 0; i < 30; i++) send_prbs(1'b0, 1'b0);
    check("bit_count_30", bit_count, exp_bits(30));
    check("err_count_30", err_count, 0);

    // err_clr colliding with a locked mismatch
    for (int i = 0; i < 5; i++) begin
      send_prbs(1'b1, 1'b0);
      send_prbs(1'b0, 1'b0);
    end
    check("five_err_count", err_count, 5);
    check("five_locked", locked, 1);
    send_prbs(1'b1, 1'b1);
    check("clr_coll_count", err_count, 0);
    check("clr_coll_pulse", err_pulse, 1);
    check("clr_coll_locked", locked, 1);
    send_prbs(1'b0, 1'b0);
    check("clr_coll_pulse_off", err_pulse, 0);

    // burst of 3 errors drops lock, then relock 12 bits later
    send_prbs(1'b1, 1'b0);
    send_prbs(1'b1, 1'b0);
    check("burst2_locked", locked, 1);
    send_prbs(1'b1, 1'b0);
    check("burst3_locked", locked, 0);
    check("burst3_err_count", err_count, 3);
    check("burst3_state", dbg_state, ST_HUNT);
    for (int i = 0; i < 11; i++) send_prbs(1'b0, 1'b0);
    check("relock_before_12", locked, 0);
    send_prbs(1'b0, 1'b0);
    check("relock_at_12", locked, 1);
    check("relock_err_count", err_count, 3);

    // asynchronous reset while locked
    #2;
    rst_n = 1'b0;
    #1;
    check("async_locked", locked, 0);
    check("async_err_count", err_count, 0);
    check("async_bit_count", bit_count, 0);
    check("async_state", dbg_state, ST_HUNT);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;

    // all-zero input never leaves HUNT
    for (int i = 0; i < 100; i++) send(1'b1, 1'b0, 1'b0);
    check("zeros_locked", locked, 0);
    check("zeros_state", dbg_state, ST_HUNT);
    check("zeros_err_count", err_count, 0);

    // valid toggling 1/0 on the stream: lock on cycle 23
    do_reset();
    for (int i = 0; i < 11; i++) begin
      send_prbs(1'b0, 1'b0);
      send(1'b0, 1'b0, 1'b0);
    end
    check("gap_locked_22", locked, 0);
    check("gap_err_pulse", err_pulse, 0);
    send_prbs(1'b0, 1'b0);
    check("gap_locked_23", locked, 1);
    send(1'b0, 1'b1, 1'b0);
    check("gap_idle_locked", locked, 1);
    check("gap_idle_pulse", err_pulse, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
